uart_tx_feeder: RTL and testbench

Byte-buffering front end that sits directly upstream of the UART transmitter.
- Accepts parallel words from the system side through a valid/ready write port and stores them in a synchronous FIFO.
- Launches words one at a time into the transmitter's data_valid/parallel_data/busy interface.
- Lets software queue a burst of bytes without polling transmitter busy.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 86 ++++++++
 rtl/uart_tx_feeder.sv | 119 +++++++++++
 tb/tb_uart_tx_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: FSM encoding, default
// word width and a constant-foldable ceil(log2) helper.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and a sticky overflow.
// Exposes the occupancy count only when UART_TX_FEEDER_LEVEL_EN is defined.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push_valid,
  input  logic [DATA_WIDTH-1:0]       push_data,
  output logic                        push_ready,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head,
  output logic                        empty,
  output logic                        full,
  output logic                        overflow
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [clog2(FIFO_DEPTH):0]  count
`endif
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count_q;
  logic [AW:0]           count_next;
  logic                  do_push;
  logic                  do_pop;

  // Ready comes only from the registered full flag, so a pop in the same
  // cycle never frees a slot for a write-through.
  assign push_ready = !full;
  assign do_push    = push_valid && !full && !flush;
  assign do_pop     = pop && !empty && !flush;
  assign head       = mem[rd_ptr];

`ifdef UART_TX_FEEDER_LEVEL_EN
  assign count = count_q;
`endif

  always_comb begin
    count_next = count_q;
    if (do_push && !do_pop) begin
      count_next = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      empty   <= (count_next == '0);
      full    <= (count_next == DEPTH_CNT);
      if (push_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system writes in a FIFO and launches them one at a time into a UART
// transmitter. Optional fifo_level output: define UART_TX_FEEDER_LEVEL_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        wr_valid,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_ready,
  input  logic                        tx_busy,
  output logic                        tx_data_valid,
  output logic [DATA_WIDTH-1:0]       tx_parallel_data,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic                        overflow,
  output logic [1:0]                  fsm_state
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level
`endif
);

  localparam logic [7:0] TIMEOUT_LOAD = 8'(ACK_TIMEOUT);

  // Write port: a word is accepted on a rising edge where wr_valid && wr_ready
  // and flush is low. Launch side: tx_data_valid is a one-cycle pulse, and the
  // transmitter acknowledges by raising tx_busy until the word is shifted out.
  feeder_state_t         state_q;
  feeder_state_t         state_next;
  logic [DATA_WIDTH-1:0] head;
  logic                  launch;
  logic                  valid_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [7:0]            timer_q;
  logic [7:0]            timer_next;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (wr_valid),
    .push_data  (wr_data),
    .push_ready (wr_ready),
    .pop        (launch),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .overflow   (overflow)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .count      (fifo_level)
`endif
  );

  assign launch    = (state_q == IDLE) && !fifo_empty && !tx_busy && !flush;
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Flush is deliberately ignored outside IDLE so an in-flight word completes.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (launch) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_q <= 8'd1) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    valid_next = launch;
    data_next  = launch ? head : tx_parallel_data;
    timer_next = 8'd0;
    if (launch) begin
      timer_next = TIMEOUT_LOAD;
    end else if (state_q == WAIT_ACK && !tx_busy && timer_q > 8'd1) begin
      timer_next = timer_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_valid    <= 1'b0;
      tx_parallel_data <= '0;
      timer_q          <= 8'd0;
    end else begin
      tx_data_valid    <= valid_next;
      tx_parallel_data <= data_next;
      timer_q          <= timer_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: vector table for latency/timeout/ack
// paths, plus hand sequences for burst, full/overflow, flush and reset.
module tb_uart_tx_feeder;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_busy;
  logic       tx_data_valid;
  logic [7:0] tx_parallel_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic [1:0] fsm_state;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [4:0] fifo_level;
`endif

  int total = 0;
  int bad = 0;
  int launches = 0;
  int busy_cnt = 0;
  bit model_on = 0;
  bit busy_force = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       busy;
    logic       fl;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_empty;
    logic       e_full;
    logic       e_ready;
    logic       e_ovf;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[15];

  uart_tx_feeder #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (16),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .wr_valid         (wr_valid),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .tx_busy          (tx_busy),
    .tx_data_valid    (tx_data_valid),
    .tx_parallel_data (tx_parallel_data),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .overflow         (overflow),
    .fsm_state        (fsm_state)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .fifo_level       (fifo_level)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: called at a falling edge, applies inputs across one rising edge and
  // returns at the next falling edge. With model_on, tx_busy is driven by a
  // transmitter model that stays busy for two cycles after every launch.
  task automatic step(input logic wv, input logic [7:0] wd, input logic fl);
    logic busy_used;
    busy_used = model_on ? (busy_cnt > 0) : busy_force;
    tx_busy  = busy_used;
    wr_valid = wv;
    wr_data  = wd;
    flush    = fl;
    @(posedge clk);
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (model_on && tx_data_valid) begin
      launches++;
      chk("launch_while_busy", {31'd0, busy_used}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_launch actual=%0h expected=none", tx_parallel_data);
      end else begin
        chk("launch_data", {24'd0, tx_parallel_data}, {24'd0, exp_q.pop_front()});
      end
      busy_cnt = 2;
    end
  endtask

  task automatic chk_outputs(input string tag, input logic v, input logic [7:0] d,
                             input logic e, input logic f, input logic r,
                             input logic o, input logic [1:0] s);
    chk({tag, "_valid"}, {31'd0, tx_data_valid}, {31'd0, v});
    chk({tag, "_data"},  {24'd0, tx_parallel_data}, {24'd0, d});
    chk({tag, "_empty"}, {31'd0, fifo_empty}, {31'd0, e});
    chk({tag, "_full"},  {31'd0, fifo_full}, {31'd0, f});
    chk({tag, "_ready"}, {31'd0, wr_ready}, {31'd0, r});
    chk({tag, "_ovf"},   {31'd0, overflow}, {31'd0, o});
    chk({tag, "_state"}, {30'd0, fsm_state}, {30'd0, s});
  endtask

  initial begin
    // Latency, timeout and ack paths: {wv, wd, busy, flush | valid, data, empty, full, ready, ovf, state}
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[3]  = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[11] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};

    // Reset held with a write pending: nothing may be pushed
    reset    = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    chk("reset_level", {27'd0, fifo_level}, 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      busy_force = vecs[i].busy;
      step(vecs[i].wv, vecs[i].wd, vecs[i].fl);
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_empty,
                  vecs[i].e_full, vecs[i].e_ready, vecs[i].e_ovf, vecs[i].e_state);
    end
    busy_force = 1'b0;
    repeat (5) step(1'b0, 8'h00, 1'b0);
    chk("settle_state", {30'd0, fsm_state}, 32'd0);

    // Burst of three under the busy model
    model_on = 1;
    busy_cnt = 0;
    launches = 0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    repeat (17) step(1'b0, 8'h00, 1'b0);
    chk("burst_launches", launches, 32'd3);
    chk("burst_left", exp_q.size(), 32'd0);
    chk("burst_empty", {31'd0, fifo_empty}, 32'd1);

    // Fill under held busy, then overflow, then drain
    model_on = 0;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0);
      exp_q.push_back(8'(8'h40 + i));
    end
    chk("fill_full", {31'd0, fifo_full}, 32'd1);
    chk("fill_ready", {31'd0, wr_ready}, 32'd0);
    chk("fill_ovf", {31'd0, overflow}, 32'd0);
    chk("fill_no_launch", {31'd0, tx_data_valid}, 32'd0);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_full", {31'd0, fifo_full}, 32'd1);
    model_on = 1;
    busy_cnt = 0;
    launches = 0;
    repeat (80) step(1'b0, 8'h00, 1'b0);
    chk("drain_launches", launches, 32'd16);
    chk("drain_left", exp_q.size(), 32'd0);
    chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
    chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("drain_state", {30'd0, fsm_state}, 32'd0);

    // Flush during WAIT_DONE with five words queued and a write pending
    model_on = 0;
    busy_force = 1'b0;
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    chk("fl_launch_valid", {31'd0, tx_data_valid}, 32'd1);
    chk("fl_launch_data", {24'd0, tx_parallel_data}, 32'hA0);
    busy_force = 1'b1;
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    step(1'b1, 8'hA4, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    chk("fl_pre_state", {30'd0, fsm_state}, 32'd2);
    chk("fl_pre_empty", {31'd0, fifo_empty}, 32'd0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    chk("fl_pre_level", {27'd0, fifo_level}, 32'd5);
`endif
    step(1'b1, 8'hEE, 1'b1);
    chk("fl_empty", {31'd0, fifo_empty}, 32'd1);
    chk("fl_ovf_clear", {31'd0, overflow}, 32'd0);
    chk("fl_state_kept", {30'd0, fsm_state}, 32'd2);
    chk("fl_ready", {31'd0, wr_ready}, 32'd1);
    busy_force = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("fl_done_state", {30'd0, fsm_state}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("fl_no_launch%0d", i), {31'd0, tx_data_valid}, 32'd0);
    end
    chk("fl_post_empty", {31'd0, fifo_empty}, 32'd1);

`ifdef UART_TX_FEEDER_LEVEL_EN
    // Level tracks pushes; simultaneous push and pop keeps it constant
    busy_force = 1'b1;
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hB3, 1'b0);
    chk("lvl_three", {27'd0, fifo_level}, 32'd3);
    busy_force = 1'b0;
    step(1'b1, 8'hB4, 1'b0);
    chk("lvl_pushpop_valid", {31'd0, tx_data_valid}, 32'd1);
    chk("lvl_pushpop_data", {24'd0, tx_parallel_data}, 32'hB1);
    chk("lvl_pushpop", {27'd0, fifo_level}, 32'd3);
`endif

    // Asynchronous reset mid-operation
    busy_force = 1'b1;
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_outputs("midrst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    chk("midrst_level", {27'd0, fifo_level}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    busy_force = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("midrst_no_launch", {31'd0, tx_data_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
